fact_seq_engine: RTL

Multi-cycle iterative factorial unit that sits downstream of the request source and replaces the single-cycle combinational factorial in timing-critical paths. It accepts an operand N through a valid/ready handshake and computes N! with one multiply per cycle. It returns the 64-bit result plus an overflow flag through a second valid/ready handshake. Only one operation is in flight at a time.

---
 rtl/fact_pkg.sv | 16 +
 rtl/fact_mul_step.sv | 21 ++
 rtl/fact_seq_engine.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fact_pkg.sv
// Shared types and constants for the iterative factorial engine.
package fact_pkg;

    localparam int FACT_N_W         = 32;
    localparam int FACT_RES_W       = 64;
    localparam int FACT_MAX_EXACT_N = 20;

    localparam logic [FACT_RES_W-1:0] FACT_SAT = {FACT_RES_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fact_state_e;

endpackage : fact_pkg

// File: rtl/fact_mul_step.sv
// One multiply step of the factorial loop: acc*cnt at full width, with an
// overflow flag raised whenever the product no longer fits in RES_W bits.
module fact_mul_step
    import fact_pkg::*;
#(
    parameter int N_W   = FACT_N_W,
    parameter int RES_W = FACT_RES_W
) (
    input  logic [RES_W-1:0] acc,
    input  logic [N_W-1:0]   cnt,
    output logic [RES_W-1:0] prod,
    output logic             ovf
);

    logic [RES_W+N_W-1:0] full_s;

    assign full_s = {{N_W{1'b0}}, acc} * {{RES_W{1'b0}}, cnt};
    assign prod   = full_s[RES_W-1:0];
    assign ovf    = |full_s[RES_W+N_W-1:RES_W];

endmodule : fact_mul_step

// File: rtl/fact_seq_engine.sv
// Iterative factorial engine: accepts N, multiplies down from N once per cycle,
// and returns N! (saturated with an overflow flag) through a valid/ready port.
module fact_seq_engine
    import fact_pkg::*;
#(
    parameter int N_W   = FACT_N_W,
    parameter int RES_W = FACT_RES_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_W-1:0]   in_n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_fact,
    output logic             out_ovf
);

    localparam logic [RES_W-1:0] ACC_ZERO = {RES_W{1'b0}};
    localparam logic [RES_W-1:0] ACC_ONE  = {{(RES_W-1){1'b0}}, 1'b1};
    localparam logic [RES_W-1:0] ACC_SAT  = {RES_W{1'b1}};
    localparam logic [N_W-1:0]   CNT_ZERO = {N_W{1'b0}};
    localparam logic [N_W-1:0]   CNT_ONE  = {{(N_W-1){1'b0}}, 1'b1};

    fact_state_e      state_q, state_d;
    logic [RES_W-1:0] acc_q, acc_d;
    logic [N_W-1:0]   cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [RES_W-1:0] out_fact_q, out_fact_d;
    logic             out_ovf_q, out_ovf_d;

    logic [RES_W-1:0] step_prod_s;
    logic             step_ovf_s;
    logic             accept_s;
    logic             release_s;
    logic             cnt_last_s;

    fact_mul_step #(
        .N_W   (N_W),
        .RES_W (RES_W)
    ) u_mul_step (
        .acc  (acc_q),
        .cnt  (cnt_q),
        .prod (step_prod_s),
        .ovf  (step_ovf_s)
    );

    assign accept_s   = in_valid && (state_q == IDLE);
    assign release_s  = out_ready && (state_q == DONE);
    assign cnt_last_s = (cnt_q <= CNT_ONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an overflowing step ends the loop early.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_last_s || step_ovf_s) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (release_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            RUN:     in_ready  = 1'b0;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Datapath next-state; result registers load on the way into DONE.
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        out_fact_d = out_fact_q;
        out_ovf_d  = out_ovf_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    acc_d = ACC_ONE;
                    cnt_d = in_n;
                    ovf_d = 1'b0;
                end else begin
                    acc_d = acc_q;
                end
            end
            RUN: begin
                if (cnt_last_s) begin
                    out_fact_d = acc_q;
                    out_ovf_d  = ovf_q;
                end else if (step_ovf_s) begin
                    ovf_d      = 1'b1;
                    acc_d      = ACC_SAT;
                    out_fact_d = ACC_SAT;
                    out_ovf_d  = 1'b1;
                end else begin
                    acc_d = step_prod_s;
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DONE: begin
                if (release_s) begin
                    out_fact_d = ACC_ZERO;
                    out_ovf_d  = 1'b0;
                end else begin
                    out_fact_d = out_fact_q;
                end
            end
            default: begin
                acc_d = acc_q;
            end
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= ACC_ZERO;
            cnt_q      <= CNT_ZERO;
            ovf_q      <= 1'b0;
            out_fact_q <= ACC_ZERO;
            out_ovf_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            out_fact_q <= out_fact_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    assign out_fact = out_fact_q;
    assign out_ovf  = out_ovf_q;

endmodule : fact_seq_engine
